// File: rtl/keypad_scanner.sv
// 4x4 hex matrix keypad scanner: row-at-a-time scan, per-scan classification,
// debounced press/release FSM, and a 16-bit shift register of accepted codes.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 256,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col_n,
   output logic [3:0]  row_n,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [15:0] value
);

   typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

   localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  STAB_DONE = 4'(DEBOUNCE_SCANS);

   logic [3:0]  col_meta_q, col_sync_q;
   logic [15:0] div_q, div_d;
   logic [1:0]  row_q, row_d;
   logic [1:0]  acc_cnt_q, acc_cnt_d;
   logic [3:0]  acc_code_q, acc_code_d;
   state_t      state_q, state_d;
   logic [3:0]  stab_q, stab_d;
   logic [3:0]  cand_q, cand_d;
   logic [3:0]  key_code_q, key_code_d;
   logic        key_valid_q, key_valid_d;
   logic [15:0] value_q, value_d;

   logic        sample, scan_end;
   logic [1:0]  hit_cnt;
   logic [3:0]  hit_code;
   logic        res_none, res_single;
   logic        accept;
   logic [3:0]  stab_inc;

   // State register (all flops)
   always_ff @(posedge clk) begin
      if (reset) begin
         col_meta_q  <= '1;
         col_sync_q  <= '1;
         div_q       <= '0;
         row_q       <= '0;
         acc_cnt_q   <= '0;
         acc_code_q  <= '0;
         state_q     <= IDLE;
         stab_q      <= '0;
         cand_q      <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         value_q     <= '0;
      end else begin
         col_meta_q  <= col_n;
         col_sync_q  <= col_meta_q;
         div_q       <= div_d;
         row_q       <= row_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         stab_q      <= stab_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         value_q     <= value_d;
      end
   end

   // Scan timing and per-scan accumulation; the row-3 sample folds in directly
   // so the scan result is available in the same cycle it completes.
   always_comb begin
      sample   = (div_q == DIV_LAST);
      scan_end = sample && (row_q == 2'd3);
      hit_cnt  = acc_cnt_q;
      hit_code = acc_code_q;
      if (sample) begin
         for (int unsigned c = 0; c < 4; c++) begin
            if (!col_sync_q[c]) begin
               if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
               hit_code = {row_q, 2'(c)};
            end
         end
      end
      div_d      = sample ? '0 : div_q + 16'd1;
      row_d      = sample ? row_q + 2'd1 : row_q;
      acc_cnt_d  = scan_end ? '0 : hit_cnt;
      acc_code_d = scan_end ? '0 : hit_code;
      res_none   = (hit_cnt == 2'd0);
      res_single = (hit_cnt == 2'd1);
   end

   // Next-state logic, evaluated once per completed scan
   always_comb begin
      state_d  = state_q;
      stab_d   = stab_q;
      cand_d   = cand_q;
      accept   = 1'b0;
      stab_inc = stab_q + 4'd1;
      if (scan_end) begin
         unique case (state_q)
            IDLE: begin
               if (res_single) begin
                  state_d = PRESS;
                  cand_d  = hit_code;
                  stab_d  = 4'd1;
               end
            end
            PRESS: begin
               if (res_single && (hit_code == cand_q)) begin
                  stab_d = stab_inc;
                  if (stab_inc == STAB_DONE) begin
                     state_d = HELD;
                     accept  = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (res_none) begin
                  state_d = RELEASE;
                  stab_d  = 4'd1;
               end
            end
            RELEASE: begin
               if (res_none) begin
                  stab_d = stab_inc;
                  if (stab_inc == STAB_DONE) state_d = IDLE;
               end else begin
                  state_d = HELD;
               end
            end
         endcase
      end
      key_valid_d = accept;
      key_code_d  = accept ? cand_q : key_code_q;
      value_d     = accept ? {value_q[11:0], cand_q} : value_q;
   end

   // Output decode
   always_comb begin
      row_n     = ~(4'b0001 << row_q);
      key_down  = (state_q == HELD) || (state_q == RELEASE);
      key_code  = key_code_q;
      key_valid = key_valid_q;
      value     = value_q;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a scan-level keypad/debounce model
// predicts accepted keys; a monitor checks every key_valid pulse against it.
module tb_keypad_scanner;

   localparam int unsigned SD       = 4;
   localparam int unsigned DB       = 3;
   localparam int unsigned SCAN_CYC = 4 * SD;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [15:0] value;
   logic [15:0] keys;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses_seen = 0;
   int pulses_exp  = 0;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] val;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // Scan-level reference model state
   bit          m_held;
   int          m_run;
   int          m_rel;
   logic [3:0]  m_cand;
   logic [15:0] m_val;
   logic [3:0]  m_last_code;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV      (SD),
      .DEBOUNCE_SCANS(DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .col_n    (col_n),
      .row_n    (row_n),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_down (key_down),
      .value    (value)
   );

   // Keypad matrix: a pressed key shorts its column to its row when that row is driven low
   always_comb begin
      col_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_held = 0; m_run = 0; m_rel = 0;
      m_cand = '0; m_val = '0; m_last_code = '0;
   endtask

   // One full scan with a constant key set; returns whether a key is accepted
   task automatic model_scan(input logic [15:0] k, output bit acc);
      int n;
      logic [3:0] code;
      n = $countones(k);
      code = '0;
      for (int i = 0; i < 16; i++) if (k[i]) code = 4'(i);
      acc = 0;
      if (!m_held) begin
         if (n == 1) begin
            if (m_run == 0) begin
               m_run = 1;
               m_cand = code;
            end else if (code == m_cand) begin
               m_run++;
            end else begin
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         if (m_run == DB) begin
            m_held = 1;
            m_run = 0;
            m_val = {m_val[11:0], m_cand};
            m_last_code = m_cand;
            acc = 1;
            pulses_exp++;
            exp_q.push_back('{m_cand, m_val});
         end
      end else begin
         if (n == 0) m_rel++;
         else m_rel = 0;
         if (m_rel == DB) begin
            m_held = 0;
            m_rel = 0;
         end
      end
   endtask

   task automatic scan(input logic [15:0] k, input int n);
      bit acc;
      logic [3:0] exp_row;
      repeat (n) begin
         keys = k;
         model_scan(k, acc);
         for (int i = 0; i < int'(SCAN_CYC); i++) begin
            exp_row = ~(4'b0001 << (i / int'(SD)));
            chk("row_n", 32'(row_n), 32'(exp_row));
            tick();
         end
         chk("key_valid", 32'(key_valid), 32'(acc));
         chk("key_down", 32'(key_down), 32'(m_held));
         chk("value", 32'(value), 32'(m_val));
         chk("key_code", 32'(key_code), 32'(m_last_code));
      end
   endtask

   // Monitor: every key_valid pulse must match the oldest predicted acceptance
   always @(negedge clk) begin
      if (!reset && key_valid) begin
         pulses_seen++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got code %0h value %0h, expected no pulse", key_code, value);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pulse_code", 32'(key_code), 32'(mon_e.code));
            chk("pulse_value", 32'(value), 32'(mon_e.val));
         end
      end
   end

   initial begin
      logic [15:0] k;
      int sel, dur;
      keys  = '0;
      reset = 1'b1;
      model_reset();
      repeat (3) tick();
      chk("rst_row_n", 32'(row_n), 32'h0000_000e);
      chk("rst_key_code", 32'(key_code), 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_key_down", 32'(key_down), 32'h0);
      chk("rst_value", 32'(value), 32'h0);
      reset = 1'b0;

      // Idle scanning
      scan(16'h0000, 3);

      // Hold key 0x9 (row 2, col 1)
      scan(16'h0001 << 9, 3);
      chk("hold9_code", 32'(key_code), 32'h9);
      chk("hold9_value", 32'(value), 32'h0009);
      chk("hold9_down", 32'(key_down), 32'h1);
      scan(16'h0001 << 9, 10);
      scan(16'h0000, 3);

      // Sequential presses shift the value register
      for (int i = 1; i <= 5; i++) begin
         scan(16'h0001 << i, 3);
         scan(16'h0000, 3);
         if (i == 4) chk("value_1234", 32'(value), 32'h1234);
      end
      chk("value_2345", 32'(value), 32'h2345);

      // Bounce on press, then a short release while held
      scan(16'h0001 << 6, 2);
      scan(16'h0000, 1);
      scan(16'h0001 << 6, 3);
      chk("bounce_code", 32'(key_code), 32'h6);
      scan(16'h0000, 2);
      scan(16'h0001 << 6, 2);
      chk("bounce_still_down", 32'(key_down), 32'h1);
      scan(16'h0000, 3);

      // Two keys together, then a second key added while held
      scan(16'h0001 | (16'h0001 << 7), 5);
      scan(16'h0000, 1);
      scan(16'h0001 << 9, 3);
      scan((16'h0001 << 9) | (16'h0001 << 3), 4);
      chk("multi_code_kept", 32'(key_code), 32'h9);
      scan(16'h0001 << 9, 2);

      // Reset mid-scan while held with the key still pressed
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      tick();
      model_reset();
      chk("mid_rst_row_n", 32'(row_n), 32'h0000_000e);
      chk("mid_rst_key_code", 32'(key_code), 32'h0);
      chk("mid_rst_key_valid", 32'(key_valid), 32'h0);
      chk("mid_rst_key_down", 32'(key_down), 32'h0);
      chk("mid_rst_value", 32'(value), 32'h0);
      reset = 1'b0;
      scan(16'h0001 << 9, 3);
      chk("rereport_code", 32'(key_code), 32'h9);
      chk("rereport_value", 32'(value), 32'h0009);
      scan(16'h0000, 3);

      // Random key activity
      for (int it = 0; it < 120; it++) begin
         sel = int'($urandom_range(0, 9));
         if (sel <= 3)      k = '0;
         else if (sel <= 8) k = 16'h0001 << $urandom_range(0, 15);
         else               k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         dur = int'($urandom_range(1, 5));
         scan(k, dur);
      end
      scan(16'h0000, 4);

      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      chk("pulse_count", 32'(pulses_seen), 32'(pulses_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
